gray_tp_sequencer: RTL and testbench
====================================

Name: gray_tp_sequencer

Overview:
- Sequential Gray-code generator that feeds the 2-bit-to-3-case Gray-to-difference decoder stage of the BCH test-pattern (TP) path.
- For each codeword, on a start pulse it walks all 2^GC_LEN Gray codes in reflected-Gray order, one per accepted cycle, so consecutive codes differ in exactly one bit.
- Supports downstream stall (hold), abort, last-code flag and a completion pulse.

Parameters:
- GC_LEN, 2, width of the Gray code; the sequence length is 2^GC_LEN.
- CNT_LEN, GC_LEN + 1, width of the internal binary counter (one extra bit detects wrap).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_start  input  1  start request; accepted only in IDLE.
- in_hold  input  1  downstream stall; while 1, the current code is held.
- in_abort  input  1  synchronous abort; returns to IDLE next edge.
- out_GC  output  GC_LEN  current Gray code to the downstream decoder.
- out_GC_valid  output  1  out_GC is presented this cycle.
- out_first  output  1  current code is the first of the sequence (all zeros).
- out_last  output  1  current code is the last of the sequence.
- out_busy  output  1  state is RUN or DONE.
- out_done  output  1  one-cycle pulse after the last code is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bin counter=0, and all outputs 0 (out_GC=0, out_GC_valid=0, out_first=0, out_last=0, out_busy=0, out_done=0).
- Gray mapping: out_GC = bin[GC_LEN-1:0] ^ (bin[GC_LEN-1:0] >> 1), registered, never computed from inputs combinationally.
- States:
  - IDLE: out_GC=0, outputs low. If in_start=1 at an edge: bin<=0, go to RUN.
  - RUN: out_GC_valid=1, out_busy=1.
    - Accept = out_GC_valid & ~in_hold.
    - On accept with bin < 2^GC_LEN-1: bin<=bin+1.
    - On accept with bin = 2^GC_LEN-1: go to DONE and drop valid.
    - With in_hold=1, out_GC, out_first and out_last are held stable.
  - DONE: out_done=1 and out_busy=1 for exactly one cycle, out_GC_valid=0; then go to IDLE and clear bin.
- Flag definitions: out_first = RUN & (bin==0); out_last = RUN & (bin==2^GC_LEN-1).
- Latency:
  - start sampled at edge t → first code valid in cycle t+1.
  - With no hold, codes occupy cycles t+1..t+2^GC_LEN, out_done is in cycle t+2^GC_LEN+1, and IDLE returns the following cycle.
- in_start is ignored in RUN and DONE: no restart and no queuing.
- in_abort has priority over everything except reset.
  - In any state, the next edge forces IDLE, bin=0 and all outputs 0.
  - No out_done is issued on abort.
- Simultaneous in_start and in_abort in IDLE: abort wins, stay IDLE.
- in_hold in IDLE or DONE has no effect; DONE always lasts exactly one cycle.
- Counter wrap: bin never exceeds 2^GC_LEN-1; the CNT_LEN MSB is always 0 (assertion target).
- Mid-operation reset: outputs clear immediately (asynchronously); the sequence restarts only on a new in_start after reset release.
- Downstream contract: consecutive accepted codes have Hamming distance 1. For GC_LEN=2 the sequence is 00,01,11,10.

Test Plan:
- Reset, then start pulse with hold=0, GC_LEN=2 → out_GC = 00,01,11,10 in cycles t+1..t+4 with valid=1; out_first only on 00; out_last only on 10; out_done=1 at t+5; busy low at t+6.
- Hold=1 for 3 cycles while out_GC=01 → 01 stays stable with valid=1 for 4 cycles total, then 11. The full sequence and done pulse shift by 3 cycles.
- in_start pulses during RUN (on code 11) and during DONE → sequence unaffected and exactly one out_done; a start in the IDLE cycle after DONE begins a new sequence at 00.
- in_abort while out_GC=11 → next cycle IDLE, all outputs 0, no out_done. A following start yields 00 first. Start and abort together in IDLE → stays IDLE.
- rst_n asserted asynchronously mid-sequence (out_GC=01), between edges → outputs go to 0 without a clock edge and stay IDLE after release until a start.
- GC_LEN=3, random hold pattern → 8 codes 000,001,011,010,110,111,101,100; every consecutive accepted pair differs in one bit; the counter MSB is never 1.

Source files
------------

// File: rtl/gray_tp_sequencer_if.sv
// Handshake bundle between a TP-path controller and the Gray-code sequencer.
// The controller (master) issues start/hold/abort; the sequencer (slave) returns the code stream.
interface gray_tp_sequencer_if #(
    parameter int GC_LEN = 2
);
    logic              in_start;
    logic              in_hold;
    logic              in_abort;
    logic [GC_LEN-1:0] out_GC;
    logic              out_GC_valid;
    logic              out_first;
    logic              out_last;
    logic              out_busy;
    logic              out_done;

    modport master (
        output in_start, in_hold, in_abort,
        input  out_GC, out_GC_valid, out_first, out_last, out_busy, out_done
    );

    modport slave (
        input  in_start, in_hold, in_abort,
        output out_GC, out_GC_valid, out_first, out_last, out_busy, out_done
    );
endinterface

// File: rtl/gray_tp_sequencer.sv
// Walks all 2^GC_LEN reflected-Gray codes once per start, feeding the Gray-to-difference
// decoder of the BCH test-pattern path; supports stall, abort, first/last flags and a done pulse.
module gray_tp_sequencer #(
    parameter int GC_LEN  = 2,
    parameter int CNT_LEN = GC_LEN + 1
) (
    input logic               clk,
    input logic               rst_n,
    gray_tp_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_LEN-1:0] LAST_BIN = CNT_LEN'((1 << GC_LEN) - 1);

    state_t             state;
    logic [CNT_LEN-1:0] bin;
    logic [CNT_LEN-1:0] bin_inc;

    assign bin_inc = bin + CNT_LEN'(1);

    function automatic logic [GC_LEN-1:0] to_gray(input logic [CNT_LEN-1:0] b);
        logic [GC_LEN-1:0] low;
        low = b[GC_LEN-1:0];
        return low ^ (low >> 1);
    endfunction

    // NOTE: every state bit and output here is a flop with an asynchronous clear, written with
    // non-blocking assignments so all of them update together from the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bin              <= '0;
            bus.out_GC       <= '0;
            bus.out_GC_valid <= 1'b0;
            bus.out_first    <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.out_busy     <= 1'b0;
            bus.out_done     <= 1'b0;
        end else if (bus.in_abort) begin
            // Abort silently drops the sequence: no done pulse.
            state            <= S_IDLE;
            bin              <= '0;
            bus.out_GC       <= '0;
            bus.out_GC_valid <= 1'b0;
            bus.out_first    <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.out_busy     <= 1'b0;
            bus.out_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.out_GC   <= '0;
                    bus.out_done <= 1'b0;
                    if (bus.in_start) begin
                        state            <= S_RUN;
                        bin              <= '0;
                        bus.out_GC_valid <= 1'b1;
                        bus.out_first    <= 1'b1;
                        bus.out_last     <= (LAST_BIN == '0);
                        bus.out_busy     <= 1'b1;
                    end else begin
                        bus.out_GC_valid <= 1'b0;
                        bus.out_first    <= 1'b0;
                        bus.out_last     <= 1'b0;
                        bus.out_busy     <= 1'b0;
                    end
                end

                S_RUN: begin
                    // Valid is always high in RUN, so a code is accepted whenever hold is low.
                    if (!bus.in_hold) begin
                        if (bin == LAST_BIN) begin
                            state            <= S_DONE;
                            bus.out_GC       <= '0;
                            bus.out_GC_valid <= 1'b0;
                            bus.out_first    <= 1'b0;
                            bus.out_last     <= 1'b0;
                            bus.out_done     <= 1'b1;
                        end else begin
                            bin           <= bin_inc;
                            bus.out_GC    <= to_gray(bin_inc);
                            bus.out_first <= 1'b0;
                            bus.out_last  <= (bin_inc == LAST_BIN);
                        end
                    end
                end

                S_DONE: begin
                    state            <= S_IDLE;
                    bin              <= '0;
                    bus.out_GC       <= '0;
                    bus.out_GC_valid <= 1'b0;
                    bus.out_first    <= 1'b0;
                    bus.out_last     <= 1'b0;
                    bus.out_busy     <= 1'b0;
                    bus.out_done     <= 1'b0;
                end

                default: begin
                    state            <= S_IDLE;
                    bin              <= '0;
                    bus.out_GC       <= '0;
                    bus.out_GC_valid <= 1'b0;
                    bus.out_first    <= 1'b0;
                    bus.out_last     <= 1'b0;
                    bus.out_busy     <= 1'b0;
                    bus.out_done     <= 1'b0;
                end
            endcase
        end
    end

    // The wrap-detect bit must never set: the counter stops at the last code.
    a_bin_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (!bin[CNT_LEN-1] && (bin <= LAST_BIN)));

endmodule

// File: tb/tb_gray_tp_sequencer.sv
// Bench for gray_tp_sequencer: directed vector table on a 2-bit instance, async-reset sequence,
// and randomized hold/start stimulus on a 3-bit instance checked against a code-list model.
module tb_gray_tp_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gray_tp_sequencer_if #(.GC_LEN(2)) b2 ();
    gray_tp_sequencer_if #(.GC_LEN(3)) b3 ();

    gray_tp_sequencer #(.GC_LEN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    gray_tp_sequencer #(.GC_LEN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       hold;
        logic       abort;
        logic [1:0] gc;
        logic       valid;
        logic       first;
        logic       last;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pack2();
        return {b2.out_GC, b2.out_GC_valid, b2.out_first, b2.out_last, b2.out_busy, b2.out_done};
    endfunction

    function automatic logic [7:0] pack3();
        return {b3.out_GC, b3.out_GC_valid, b3.out_first, b3.out_last, b3.out_busy, b3.out_done};
    endfunction

    task automatic add(input logic s, input logic h, input logic a, input logic [1:0] g,
                       input logic v, input logic f, input logic l, input logic b, input logic d);
        vec_t t;
        t.start = s; t.hold = h; t.abort = a; t.gc = g;
        t.valid = v; t.first = f; t.last = l; t.busy = b; t.done = d;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step2(input logic s, input logic h, input logic a);
        @(negedge clk);
        b2.in_start = s; b2.in_hold = h; b2.in_abort = a;
        @(posedge clk);
        #1;
    endtask

    // Reference: the reflected-Gray order listed explicitly for an 8-code walk.
    int gray8[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    task automatic run_rand_seq(input int seq_no);
        int       idx;
        int       cycles;
        bit       finished;
        bit       seen_done;
        bit       h;
        logic [2:0] prev;
        idx = 0; cycles = 0; finished = 0; seen_done = 0; prev = '0;
        @(negedge clk);
        b3.in_start = 1'b1; b3.in_hold = 1'(($urandom) & 1); b3.in_abort = 1'b0;
        while (!finished && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (idx < 8) begin
                check($sformatf("rand%0d code%0d", seq_no, idx), {24'd0, pack3()},
                      {24'd0, 3'(gray8[idx]), 1'b1, (idx == 0), (idx == 7), 1'b1, 1'b0});
                h = ($urandom_range(0, 2) == 0);
                b3.in_hold  = h;
                b3.in_start = 1'(($urandom) & 1);
                if (!h) begin
                    if (idx > 0)
                        check($sformatf("rand%0d hamming%0d", seq_no, idx),
                              32'($countones(b3.out_GC ^ prev)), 32'd1);
                    prev = b3.out_GC;
                    idx++;
                end
            end else if (!seen_done) begin
                check($sformatf("rand%0d done", seq_no), {24'd0, pack3()}, 32'h03);
                seen_done   = 1;
                b3.in_hold  = 1'(($urandom) & 1);
                b3.in_start = 1'(($urandom) & 1);
            end else begin
                check($sformatf("rand%0d idle", seq_no), {24'd0, pack3()}, 32'h00);
                b3.in_start = 1'b0;
                b3.in_hold  = 1'b0;
                finished    = 1;
            end
        end
        if (!finished) check($sformatf("rand%0d timeout", seq_no), 32'd1, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b2.in_start = 1'b0; b2.in_hold = 1'b0; b2.in_abort = 1'b0;
        b3.in_start = 1'b0; b3.in_hold = 1'b0; b3.in_abort = 1'b0;

        // start hold abort | gc valid first last busy done
        add(1,0,0, 2'b00, 1,1,0,1,0);
        add(0,0,0, 2'b01, 1,0,0,1,0);
        add(0,0,0, 2'b11, 1,0,0,1,0);
        add(0,0,0, 2'b10, 1,0,1,1,0);
        add(0,0,0, 2'b00, 0,0,0,1,1);
        add(0,0,0, 2'b00, 0,0,0,0,0);
        add(1,0,0, 2'b00, 1,1,0,1,0);
        add(0,0,0, 2'b01, 1,0,0,1,0);
        add(0,1,0, 2'b01, 1,0,0,1,0);
        add(0,1,0, 2'b01, 1,0,0,1,0);
        add(0,1,0, 2'b01, 1,0,0,1,0);
        add(0,0,0, 2'b11, 1,0,0,1,0);
        add(0,0,0, 2'b10, 1,0,1,1,0);
        add(0,1,0, 2'b10, 1,0,1,1,0);
        add(0,0,0, 2'b00, 0,0,0,1,1);
        add(0,1,0, 2'b00, 0,0,0,0,0);
        add(1,0,0, 2'b00, 1,1,0,1,0);
        add(0,0,0, 2'b01, 1,0,0,1,0);
        add(1,0,0, 2'b11, 1,0,0,1,0);
        add(1,0,0, 2'b10, 1,0,1,1,0);
        add(0,0,0, 2'b00, 0,0,0,1,1);
        add(1,1,0, 2'b00, 0,0,0,0,0);
        add(1,0,0, 2'b00, 1,1,0,1,0);
        add(0,0,0, 2'b01, 1,0,0,1,0);
        add(0,0,0, 2'b11, 1,0,0,1,0);
        add(0,0,1, 2'b00, 0,0,0,0,0);
        add(0,0,0, 2'b00, 0,0,0,0,0);
        add(1,0,1, 2'b00, 0,0,0,0,0);
        add(1,0,0, 2'b00, 1,1,0,1,0);
        add(0,0,0, 2'b01, 1,0,0,1,0);

        repeat (2) @(negedge clk);
        check("reset gc2", {25'd0, pack2()}, 32'd0);
        check("reset gc3", {24'd0, pack3()}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step2(vecs[i].start, vecs[i].hold, vecs[i].abort);
            check($sformatf("vec%0d", i), {25'd0, pack2()},
                  {25'd0, vecs[i].gc, vecs[i].valid, vecs[i].first, vecs[i].last,
                   vecs[i].busy, vecs[i].done});
        end

        // Mid-sequence asynchronous reset while out_GC=01, between clock edges.
        #1 rst_n = 1'b0;
        #1 check("async reset clears", {25'd0, pack2()}, 32'd0);
        @(negedge clk);
        b2.in_start = 1'b0; b2.in_hold = 1'b0; b2.in_abort = 1'b0;
        rst_n = 1'b1;
        step2(0, 0, 0);
        check("post reset idle a", {25'd0, pack2()}, 32'd0);
        step2(0, 0, 0);
        check("post reset idle b", {25'd0, pack2()}, 32'd0);
        step2(1, 0, 0);
        check("post reset start", {25'd0, pack2()}, {25'd0, 2'b00, 5'b11010});
        step2(0, 0, 1);
        check("abort after restart", {25'd0, pack2()}, 32'd0);
        b2.in_abort = 1'b0;

        for (int s = 0; s < 20; s++) run_rand_seq(s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
